// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
//   Stimulus source for the serial sequence detector. A pattern of 1..WIDTH
//   bits is loaded in parallel. It is then shifted out MSB-first, one bit per
//   clock, on sout. A run can be a single pass or repeat without a gap, and
//   stop aborts it. done pulses on the last bit of every pass.
//
// Ports
//   clk          system clock, rising edge
//   clr          asynchronous active-high reset, clears all state
//   load         capture pattern/len (legal only for 1 <= len <= WIDTH)
//   pattern      pattern bits, bit len-1 is sent first
//   len          number of bits to send
//   repeat_mode  1 = wrap to the first bit after the last one (sampled at the
//                last-bit edge); named this way because "repeat" is a
//                SystemVerilog keyword
//   start        begin shifting from READY
//   stop         abort shifting, back to READY without a done pulse
//   sout         registered serial data bit
//   valid        high while sout carries a pattern bit
//   done         high while sout carries the last bit of a pass
//   busy         high in RUN
//   bit_idx      1-based index of the bit on sout, 0 outside RUN
//   stat         state code: 00 IDLE, 01 READY, 10 RUN
//
// Handshake: valid has no back-pressure. A consumer must take sout on every
// rising edge where valid is high, and it must ignore sout when valid is low.
module seq_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    input  logic             repeat_mode,
    input  logic             start,
    input  logic             stop,
    output logic             sout,
    output logic             valid,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] bit_idx,
    output logic [1:0]       stat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READY = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    localparam logic [CNT_W:0] MAX_LEN = (CNT_W + 1)'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] pat_reg;
    logic [CNT_W-1:0] len_reg;

    logic             load_ok;
    logic [CNT_W-1:0] first_sel;
    logic [CNT_W-1:0] next_sel;
    logic [WIDTH-1:0] first_shift;
    logic [WIDTH-1:0] next_shift;
    logic             first_bit;
    logic             next_bit;
    logic             last_bit;
    logic [CNT_W-1:0] idx_inc;

    // A load with an out-of-range length is dropped as if it never happened.
    assign load_ok = load && (len != '0) && ({1'b0, len} <= MAX_LEN);

    // bit_idx is 1-based. The bit after position bit_idx is therefore
    // pattern[len-1-bit_idx]. Shifting and then taking bit 0 keeps the
    // select width-clean.
    assign first_sel   = len_reg - CNT_W'(1);
    assign next_sel    = len_reg - bit_idx - CNT_W'(1);
    assign first_shift = pat_reg >> first_sel;
    assign next_shift  = pat_reg >> next_sel;
    assign first_bit   = first_shift[0];
    assign next_bit    = next_shift[0];
    assign last_bit    = (bit_idx == len_reg);
    assign idx_inc     = bit_idx + CNT_W'(1);

    // state is itself a register, so stat is a registered output.
    assign stat = state;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= ST_IDLE;
            pat_reg <= '0;
            len_reg <= '0;
            sout    <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_ok) begin
                        pat_reg <= pattern;
                        len_reg <= len;
                        state   <= ST_READY;
                    end
                end
                ST_READY: begin
                    // A legal load beats start in the same cycle.
                    if (load_ok) begin
                        pat_reg <= pattern;
                        len_reg <= len;
                    end else if (start) begin
                        state   <= ST_RUN;
                        sout    <= first_bit;
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        bit_idx <= CNT_W'(1);
                        done    <= (len_reg == CNT_W'(1));
                    end
                end
                ST_RUN: begin
                    // stop wins over both wrap and normal advance.
                    if (stop || (last_bit && !repeat_mode)) begin
                        state   <= ST_READY;
                        sout    <= 1'b0;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        bit_idx <= '0;
                    end else if (last_bit) begin
                        // Wrap with no gap cycle.
                        sout    <= first_bit;
                        bit_idx <= CNT_W'(1);
                        done    <= (len_reg == CNT_W'(1));
                    end else begin
                        sout    <= next_bit;
                        bit_idx <= idx_inc;
                        done    <= (idx_inc == len_reg);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;
    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] len;
    logic             rpt;
    logic             start;
    logic             stop;
    logic             sout;
    logic             valid;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] bit_idx;
    logic [1:0]       stat;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of bits still to be sent in the current pass.
    bit               m_loaded;
    bit               m_run;
    logic [WIDTH-1:0] m_pat;
    int               m_len;
    bit               m_q[$];

    seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .load(load), .pattern(pattern), .len(len),
        .repeat_mode(rpt), .start(start), .stop(stop),
        .sout(sout), .valid(valid), .done(done), .busy(busy),
        .bit_idx(bit_idx), .stat(stat)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loaded = 0;
        m_run    = 0;
        m_pat    = '0;
        m_len    = 0;
        m_q.delete();
    endtask

    task automatic model_refill();
        for (int i = m_len - 1; i >= 0; i--) m_q.push_back(m_pat[i]);
    endtask

    // Applies one rising edge to the model, using the inputs sampled at that edge.
    task automatic model_edge();
        bit legal;
        legal = load && (int'(len) >= 1) && (int'(len) <= WIDTH);
        if (m_run) begin
            if (stop) begin
                m_run = 0;
                m_q.delete();
            end else begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    if (rpt) model_refill();
                    else m_run = 0;
                end
            end
        end else if (legal) begin
            m_pat    = pattern;
            m_len    = int'(len);
            m_loaded = 1;
        end else if (m_loaded && start) begin
            model_refill();
            m_run = 1;
        end
    endtask

    task automatic check_outputs();
        if (m_run) begin
            chk("sout", sout, m_q[0]);
            chk("valid", valid, 1);
            chk("busy", busy, 1);
            chk("done", done, m_q.size() == 1);
            chk("bit_idx", bit_idx, m_len - m_q.size() + 1);
            chk("stat", stat, 2);
        end else begin
            chk("sout", sout, 0);
            chk("valid", valid, 0);
            chk("busy", busy, 0);
            chk("done", done, 0);
            chk("bit_idx", bit_idx, 0);
            chk("stat", stat, m_loaded ? 1 : 0);
        end
    endtask

    // Driver: advance one clock, update the model, then compare #1 after the edge.
    task automatic step();
        @(posedge clk);
        if (clr) model_reset();
        else model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; stop = 0;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] p, input logic [CNT_W-1:0] l);
        load = 1; pattern = p; len = l;
        step();
        load = 0;
    endtask

    task automatic pulse_clr();
        clr = 1;
        step();
        clr = 0;
    endtask

    initial begin
        logic [3:0] exp4;
        logic [5:0] exp6;
        clr = 1; load = 0; start = 0; stop = 0; rpt = 0;
        pattern = '0; len = '0;
        model_reset();

        // Reset held with load/start toggling
        for (int i = 0; i < 5; i++) begin
            load = i[0]; start = ~i[0]; pattern = 16'hFFFF; len = 5'd4;
            step();
            chk("rst_stat", stat, 0);
            chk("rst_sout", sout, 0);
        end
        clr = 0;
        idle_inputs();
        start = 1;
        step();
        start = 0;
        chk("start_in_idle_stat", stat, 0);

        // Single pass, pattern 1011
        do_load(16'h000B, 5'd4);
        chk("loaded_stat", stat, 1);
        exp4 = 4'b1011;
        rpt = 0; start = 1;
        step();
        start = 0;
        for (int k = 0; k < 4; k++) begin
            chk("single_sout", sout, exp4[3-k]);
            chk("single_idx", bit_idx, k + 1);
            chk("single_done", done, k == 3);
            step();
        end
        chk("single_end_stat", stat, 1);
        chk("single_end_sout", sout, 0);

        // Repeat then stop in the middle of pass 2
        do_load(16'h0006, 5'd3);
        exp6 = 6'b110110;
        rpt = 1; start = 1;
        step();
        start = 0;
        for (int k = 0; k < 5; k++) begin
            chk("rep_sout", sout, exp6[5-k]);
            chk("rep_done", done, (k % 3) == 2);
            if (k == 4) stop = 1;
            step();
        end
        stop = 0;
        chk("stop_sout", sout, 0);
        chk("stop_valid", valid, 0);
        chk("stop_stat", stat, 1);
        chk("stop_done", done, 0);
        rpt = 0;

        // Illegal loads from IDLE
        pulse_clr();
        do_load(16'h1234, 5'd0);
        chk("len0_stat", stat, 0);
        do_load(16'h1234, 5'd17);
        chk("len17_stat", stat, 0);
        do_load(16'h001F, 5'd5);
        chk("legal_stat", stat, 1);
        // load and start together: the load wins
        load = 1; start = 1; pattern = 16'h0001; len = 5'd2;
        step();
        load = 0; start = 0;
        chk("ldst_stat", stat, 1);
        chk("ldst_valid", valid, 0);
        start = 1;
        step();
        start = 0;
        chk("new_pat_b0", sout, 0);
        chk("new_pat_idx", bit_idx, 1);
        // A load during RUN must not disturb the sequence
        load = 1; pattern = 16'hFFFF; len = 5'd16;
        step();
        load = 0;
        chk("run_load_sout", sout, 1);
        chk("run_load_idx", bit_idx, 2);
        chk("run_load_done", done, 1);
        step();
        chk("run_load_end", stat, 1);

        // Asynchronous reset in the middle of a run
        do_load(16'h00AA, 5'd8);
        start = 1;
        step();
        start = 0;
        step();
        step();
        chk("pre_clr_idx", bit_idx, 3);
        #2 clr = 1;
        #1;
        chk("async_sout", sout, 0);
        chk("async_valid", valid, 0);
        chk("async_busy", busy, 0);
        chk("async_idx", bit_idx, 0);
        chk("async_stat", stat, 0);
        step();
        clr = 0;
        start = 1;
        step();
        start = 0;
        chk("post_clr_start", stat, 0);

        // len=1 with repeat: done stays high
        do_load(16'h0001, 5'd1);
        rpt = 1; start = 1;
        step();
        start = 0;
        for (int k = 0; k < 4; k++) begin
            chk("len1_sout", sout, 1);
            chk("len1_done", done, 1);
            step();
        end
        rpt = 0;
        step();
        chk("len1_end_stat", stat, 1);
        chk("len1_end_done", done, 0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            clr   = ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            rpt   = $urandom_range(0, 1);
            pattern = WIDTH'($urandom);
            if ($urandom_range(0, 9) < 8) len = CNT_W'($urandom_range(1, WIDTH));
            else len = ($urandom_range(0, 1) == 0) ? 5'd0 : CNT_W'($urandom_range(WIDTH + 1, 31));
            // Keep an illegal load away from start so the two never meet.
            if (load && (len == 0 || int'(len) > WIDTH)) start = 0;
            step();
        end
        clr = 0;
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Upstream stimulus stage for the serial sequence detector.
- Holds a loaded parallel pattern and shifts it out MSB-first, one bit per clock, on `sout`; `sout` drives the detector's `din`.
- Supports single-pass or continuous repeat, abort, and a per-pass done pulse.
- Exposes a state code (`stat`) for lab observation.

Parameters:
- WIDTH, 16, maximum pattern length in bits.
- CNT_W, 5, width of the length and bit-index fields; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  reset, asynchronous, active-high; clears all state immediately.
- load  input  1  capture `pattern` and `len` (sampled at clk rise).
- pattern  input  WIDTH  pattern bits; bit len-1 is sent first, bit 0 last.
- len  input  CNT_W  number of bits to send; legal range 1..WIDTH.
- repeat  input  1  1 = wrap to the first bit after the last bit; sampled at each last-bit edge.
- start  input  1  begin shifting from READY.
- stop  input  1  abort shifting.
- sout  output  1  registered serial data bit.
- valid  output  1  high while `sout` carries a pattern bit.
- done  output  1  one-cycle pulse coincident with the last bit of each pass.
- busy  output  1  high in RUN.
- bit_idx  output  CNT_W  1-based index of the bit currently on `sout` (1..len); 0 outside RUN.
- stat  output  2  state code: 00 IDLE, 01 READY, 10 RUN; 11 is never produced.

Behaviour:
- Reset (`clr`=1, async): state=IDLE, shift/pattern regs=0, len_reg=0, sout=0, valid=0, done=0, busy=0, bit_idx=0, stat=00. Takes effect without waiting for a clock edge, including mid-RUN. The loaded pattern is lost.
- IDLE:
  - load with 1<=len<=WIDTH -> capture pattern/len, next state READY.
  - load with len=0 or len>WIDTH -> ignored, stay IDLE.
  - start and stop -> ignored.
- READY:
  - Legal load -> recapture, stay READY; an illegal load is ignored.
  - load and start in the same cycle -> load wins, start ignored.
  - start (without load) -> at that edge enter RUN; sout<=bit len-1, valid=1, bit_idx=1, busy=1.
- RUN (one bit per cycle):
  - At the edge k after the start edge, sout=bit len-1-k and bit_idx=k+1, for k=0..len-1.
  - load is ignored throughout RUN.
  - Last bit (bit_idx=len): done=1 for that cycle.
  - Next edge after the last bit, repeat=1 -> sout=bit len-1, bit_idx=1, no gap cycle; the pattern is unchanged.
  - Next edge after the last bit, repeat=0 -> READY; sout=0, valid=0, busy=0, bit_idx=0.
- stop in RUN:
  - Next edge -> READY, sout=0, valid=0, bit_idx=0, no done pulse.
  - stop has priority over both wrap and normal advance.
  - start in RUN is ignored.
- len=1: every pass is one cycle; done stays high continuously while repeating.
- Output timing: all outputs are registered, and sout/valid/done/bit_idx change only on clk rise (except on `clr`). There is no combinational path from inputs to outputs.

Test Plan:
- Reset: clr=1 for 0–50 ns, with load/start toggling -> sout=valid=done=busy=0, bit_idx=0, stat=00 throughout; stat stays 00 until the first legal load after release.
- Single pass: load pattern=16'h000B, len=4; then start -> sout=1,0,1,1 on four consecutive cycles; bit_idx=1,2,3,4; valid high for exactly 4 cycles; done high only in cycle 4. Then stat=01 and sout=0.
- Repeat and stop: load pattern=16'h0006, len=3, repeat=1, start -> sout=1,1,0,1,1,0,… with done every 3rd cycle. Assert stop during the 2nd bit of pass 2 -> next edge sout=0, valid=0, stat=01, no done.
- Illegal and conflicting commands:
  - load with len=0, then len=17, from IDLE -> stat stays 00.
  - In READY, load+start in the same cycle -> new pattern captured, stat stays 01, valid stays 0.
  - load during RUN -> output sequence unchanged.
- Async reset mid-run: load 16'h00AA, len=8, start; assert clr between edges while bit_idx=3 -> all outputs 0 before the next clk rise. After release, start alone is ignored (stat=00) until a new legal load.
- len=1, repeat=1, pattern bit0=1 -> sout=1, valid=1, done=1 continuously; drop repeat -> after the next edge stat=01, done=0.
